// File: rtl/spi_axis_slave.sv
`default_nettype none
// ============================================================================
// Module   : spi_axis_slave
// Purpose  : SPI mode-0 responder bridging an external SPI master to
//            AXI-Stream. The SPI pins are oversampled in the clk domain.
//            MOSI is deserialised into bytes on an AXIS master port, and
//            bytes taken from an AXIS slave port are serialised onto MISO.
// Ports    : clk, resn (async, active-low)
//            spi_clk/spi_csn/spi_mosi in, spi_miso/spi_miso_oe out
//            m_axis_* : received bytes (master side)
//            s_axis_* : bytes to transmit (slave side)
//            busy, frame_done, rx_overflow_count, tx_underrun_count
// Notes    : clk must run at least 8x the SPI clock. SYNC_STAGES >= 2.
// Revision : 1.0 - initial release
// ============================================================================
module spi_axis_slave #(
    parameter bit         MSB_FIRST   = 1'b1,
    parameter logic [7:0] FILL_BYTE   = 8'hFF,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       resn,
    input  logic       spi_clk,
    input  logic       spi_csn,
    input  logic       spi_mosi,
    output logic       spi_miso,
    output logic       spi_miso_oe,
    output logic [7:0] m_axis_tdata,
    output logic       m_axis_tvalid,
    input  logic       m_axis_tready,
    input  logic [7:0] s_axis_tdata,
    input  logic       s_axis_tvalid,
    output logic       s_axis_tready,
    output logic       busy,
    output logic       frame_done,
    output logic [7:0] rx_overflow_count,
    output logic [7:0] tx_underrun_count
);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // Pin synchronisers plus one extra stage for edge detection.
    // CSN resets to the deselected level so reset never fakes a csn_fall.
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sclk_sync_q;
    logic [SYNC_STAGES-1:0] csn_sync_q;
    logic [SYNC_STAGES-1:0] mosi_sync_q;
    logic                   sclk_prev_q;
    logic                   csn_prev_q;

    always_ff @(posedge clk or negedge resn) begin
        if (!resn) begin
            sclk_sync_q <= '0;
            csn_sync_q  <= '1;
            mosi_sync_q <= '0;
            sclk_prev_q <= 1'b0;
            csn_prev_q  <= 1'b1;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi_clk};
            csn_sync_q  <= {csn_sync_q[SYNC_STAGES-2:0], spi_csn};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
            sclk_prev_q <= sclk_sync_q[SYNC_STAGES-1];
            csn_prev_q  <= csn_sync_q[SYNC_STAGES-1];
        end
    end

    logic w_sclk, w_csn, w_mosi;
    logic w_sclk_rise, w_sclk_fall, w_csn_fall, w_csn_rise;

    assign w_sclk      = sclk_sync_q[SYNC_STAGES-1];
    assign w_csn       = csn_sync_q[SYNC_STAGES-1];
    assign w_mosi      = mosi_sync_q[SYNC_STAGES-1];
    assign w_sclk_rise =  w_sclk & ~sclk_prev_q;
    assign w_sclk_fall = ~w_sclk &  sclk_prev_q;
    assign w_csn_fall  = ~w_csn  &  csn_prev_q;
    assign w_csn_rise  =  w_csn  & ~csn_prev_q;

    // ------------------------------------------------------------------
    // Frame state and datapath
    // ------------------------------------------------------------------
    state_t     state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic       byte_done_q, byte_done_d;   // a byte completed, next TX byte owed
    logic [7:0] rx_shift_q, rx_shift_d;
    logic [7:0] tx_shift_q, tx_shift_d;
    logic       miso_q, miso_d;
    logic [7:0] tdata_q, tdata_d;
    logic       tvalid_q, tvalid_d;
    logic       frame_done_q, frame_done_d;
    logic [7:0] rx_ovf_q, rx_ovf_d;
    logic [7:0] tx_unr_q, tx_unr_d;

    logic       w_tx_load;
    logic [7:0] w_tx_byte;
    logic [7:0] w_rx_next;

    assign w_tx_byte = s_axis_tvalid ? s_axis_tdata : FILL_BYTE;
    assign w_rx_next = MSB_FIRST ? {rx_shift_q[6:0], w_mosi}
                                 : {w_mosi, rx_shift_q[7:1]};

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        byte_done_d  = byte_done_q;
        rx_shift_d   = rx_shift_q;
        tx_shift_d   = tx_shift_q;
        miso_d       = miso_q;
        tdata_d      = tdata_q;
        tvalid_d     = tvalid_q;
        frame_done_d = 1'b0;
        rx_ovf_d     = rx_ovf_q;
        tx_unr_d     = tx_unr_q;
        w_tx_load    = 1'b0;

        // Downstream accept; a byte completing this cycle overrides below.
        if (tvalid_q && m_axis_tready) begin
            tvalid_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                miso_d = 1'b0;
                if (w_csn_fall) begin
                    state_d     = ST_ACTIVE;
                    bit_cnt_d   = 3'd0;
                    byte_done_d = 1'b0;
                    w_tx_load   = 1'b1;
                end
            end
            ST_ACTIVE: begin
                // Deselect wins over any SCLK edge seen in the same cycle.
                if (w_csn_rise) begin
                    state_d      = ST_IDLE;
                    bit_cnt_d    = 3'd0;
                    byte_done_d  = 1'b0;
                    frame_done_d = 1'b1;
                    miso_d       = 1'b0;
                end else if (w_sclk_rise) begin
                    rx_shift_d = w_rx_next;
                    bit_cnt_d  = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        byte_done_d = 1'b1;
                        if (!tvalid_q || m_axis_tready) begin
                            tdata_d  = w_rx_next;
                            tvalid_d = 1'b1;
                        end else if (rx_ovf_q != 8'hFF) begin
                            rx_ovf_d = rx_ovf_q + 8'd1;
                        end
                    end
                end else if (w_sclk_fall) begin
                    if (bit_cnt_q != 3'd0) begin
                        miso_d     = MSB_FIRST ? tx_shift_q[7] : tx_shift_q[0];
                        tx_shift_d = MSB_FIRST ? {tx_shift_q[6:0], 1'b0}
                                               : {1'b0, tx_shift_q[7:1]};
                    end else if (byte_done_q) begin
                        byte_done_d = 1'b0;
                        w_tx_load   = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // TX byte load: first bit goes straight onto MISO, the rest is
        // pre-shifted so each later sclk_fall takes the shifter's end bit.
        if (w_tx_load) begin
            miso_d     = MSB_FIRST ? w_tx_byte[7] : w_tx_byte[0];
            tx_shift_d = MSB_FIRST ? {w_tx_byte[6:0], 1'b0}
                                   : {1'b0, w_tx_byte[7:1]};
            if (!s_axis_tvalid && (tx_unr_q != 8'hFF)) begin
                tx_unr_d = tx_unr_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge resn) begin
        if (!resn) begin
            state_q      <= ST_IDLE;
            bit_cnt_q    <= 3'd0;
            byte_done_q  <= 1'b0;
            rx_shift_q   <= 8'h00;
            tx_shift_q   <= 8'h00;
            miso_q       <= 1'b0;
            tdata_q      <= 8'h00;
            tvalid_q     <= 1'b0;
            frame_done_q <= 1'b0;
            rx_ovf_q     <= 8'h00;
            tx_unr_q     <= 8'h00;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            byte_done_q  <= byte_done_d;
            rx_shift_q   <= rx_shift_d;
            tx_shift_q   <= tx_shift_d;
            miso_q       <= miso_d;
            tdata_q      <= tdata_d;
            tvalid_q     <= tvalid_d;
            frame_done_q <= frame_done_d;
            rx_ovf_q     <= rx_ovf_d;
            tx_unr_q     <= tx_unr_d;
        end
    end

    // The handshake happens in the load cycle itself, so tready is a
    // single-cycle pulse that can only occur alongside tvalid.
    assign s_axis_tready     = w_tx_load & s_axis_tvalid;
    assign busy              = (state_q == ST_ACTIVE);
    assign spi_miso_oe       = busy;
    assign spi_miso          = miso_q;
    assign m_axis_tdata      = tdata_q;
    assign m_axis_tvalid     = tvalid_q;
    assign frame_done        = frame_done_q;
    assign rx_overflow_count = rx_ovf_q;
    assign tx_underrun_count = tx_unr_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_axis_slave.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_axis_slave
// Purpose  : Directed bench for spi_axis_slave. Two instances are built,
//            index 0 with MSB_FIRST=1 and index 1 with MSB_FIRST=0, and the
//            same suite of frames is run against each in turn.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_axis_slave;

    localparam int HALF = 8;   // clk cycles per SPI half period

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       resn;
    logic       sclk    [2];
    logic       csn     [2];
    logic       mosi    [2];
    logic       miso    [2];
    logic       oe      [2];
    logic [7:0] mtdata  [2];
    logic       mtvalid [2];
    logic       mtready [2];
    logic [7:0] stdata  [2];
    logic       stvalid [2];
    logic       stready [2];
    logic       busy    [2];
    logic       fdone   [2];
    logic [7:0] rxov    [2];
    logic [7:0] txun    [2];

    generate
        for (genvar u = 0; u < 2; u++) begin : g_dut
            spi_axis_slave #(
                .MSB_FIRST  (u == 0),
                .FILL_BYTE  (8'hFF),
                .SYNC_STAGES(2)
            ) dut (
                .clk              (clk),
                .resn             (resn),
                .spi_clk          (sclk[u]),
                .spi_csn          (csn[u]),
                .spi_mosi         (mosi[u]),
                .spi_miso         (miso[u]),
                .spi_miso_oe      (oe[u]),
                .m_axis_tdata     (mtdata[u]),
                .m_axis_tvalid    (mtvalid[u]),
                .m_axis_tready    (mtready[u]),
                .s_axis_tdata     (stdata[u]),
                .s_axis_tvalid    (stvalid[u]),
                .s_axis_tready    (stready[u]),
                .busy             (busy[u]),
                .frame_done       (fdone[u]),
                .rx_overflow_count(rxov[u]),
                .tx_underrun_count(txun[u])
            );
        end
    endgenerate

    // ------------------------------------------------------------------
    // TX byte source: an append-only list per unit, consumed on tready.
    // ------------------------------------------------------------------
    logic [7:0] tx_list [2][64];
    int         tx_len  [2] = '{0, 0};
    int         tx_idx  [2] = '{0, 0};

    always_comb begin
        for (int k = 0; k < 2; k++) begin
            stvalid[k] = (tx_idx[k] < tx_len[k]);
            stdata[k]  = tx_list[k][tx_idx[k][5:0]];
        end
    end

    // RX beat log, frame_done and handshake-rule monitors.
    logic [7:0] rx_log  [2][64];
    int         rx_n    [2] = '{0, 0};
    int         fd_n    [2] = '{0, 0};
    int         bad_rdy [2] = '{0, 0};

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (stready[k]) tx_idx[k] <= tx_idx[k] + 1;
            if (stready[k] && !stvalid[k]) bad_rdy[k] <= bad_rdy[k] + 1;
            if (mtvalid[k] && mtready[k] && rx_n[k] < 64) begin
                rx_log[k][rx_n[k]] <= mtdata[k];
                rx_n[k]            <= rx_n[k] + 1;
            end
            if (fdone[k]) fd_n[k] <= fd_n[k] + 1;
        end
    end

    // ------------------------------------------------------------------
    // Checking
    // ------------------------------------------------------------------
    int n_checks = 0;
    int n_pass   = 0;
    int cur_u    = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL u%0d %s: got %0h, expected %0h", cur_u, tag, got, exp);
    endtask

    task automatic push(input int u, input logic [7:0] b);
        tx_list[u][tx_len[u]] = b;
        tx_len[u]             = tx_len[u] + 1;
    endtask

    // ------------------------------------------------------------------
    // SPI master model (mode 0). On the final bit of a finished frame the
    // falling SCLK and rising CSN happen together.
    // ------------------------------------------------------------------
    logic [7:0] mosi_bytes [8];
    logic [7:0] miso_bytes [8];

    task automatic spi_frame(input int u, input int nbits, input bit end_frame);
        int b;
        int pos;
        @(negedge clk);
        csn[u]  = 1'b0;
        mosi[u] = 1'b0;
        for (int i = 0; i < 8; i++) miso_bytes[i] = 8'h00;
        repeat (HALF) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            b   = i / 8;
            pos = (u == 0) ? (7 - (i % 8)) : (i % 8);
            mosi[u] = mosi_bytes[b][pos];
            repeat (HALF) @(negedge clk);
            sclk[u] = 1'b1;
            miso_bytes[b][pos] = miso[u];
            repeat (HALF) @(negedge clk);
            sclk[u] = 1'b0;
            if (i == nbits - 1 && end_frame) csn[u] = 1'b1;
        end
        repeat (4 * HALF) @(negedge clk);
    endtask

    task automatic run_suite(input int u);
        int rb, tb0, fb;
        cur_u = u;

        // Reset state
        @(negedge clk);
        resn       = 1'b0;
        sclk[u]    = 1'b0;
        csn[u]     = 1'b1;
        mosi[u]    = 1'b0;
        mtready[u] = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_miso_oe", {miso[u], oe[u]}, 2'b00);
        check("rst_flags", {mtvalid[u], stready[u], busy[u], fdone[u]}, 4'b0000);
        check("rst_tdata", mtdata[u], 8'h00);
        check("rst_counters", {rxov[u], txun[u]}, 16'h0000);
        resn = 1'b1;
        repeat (5) @(negedge clk);

        // Single frame
        push(u, 8'h3C);
        mosi_bytes[0] = 8'hA5;
        rb = rx_n[u]; tb0 = tx_idx[u]; fb = fd_n[u];
        spi_frame(u, 8, 1'b1);
        check("single_beats", rx_n[u] - rb, 1);
        check("single_rx", rx_log[u][rb], 8'hA5);
        check("single_miso", miso_bytes[0], 8'h3C);
        check("single_fdone", fd_n[u] - fb, 1);
        check("single_tready", tx_idx[u] - tb0, 1);
        check("single_counters", {rxov[u], txun[u]}, 16'h0000);
        check("single_idle", {busy[u], oe[u], miso[u], mtvalid[u]}, 4'b0000);

        // 4-byte burst
        push(u, 8'h10); push(u, 8'h20); push(u, 8'h30); push(u, 8'h40);
        mosi_bytes[0] = 8'h01; mosi_bytes[1] = 8'h02;
        mosi_bytes[2] = 8'h03; mosi_bytes[3] = 8'h04;
        rb = rx_n[u]; tb0 = tx_idx[u]; fb = fd_n[u];
        spi_frame(u, 32, 1'b1);
        check("burst_beats", rx_n[u] - rb, 4);
        check("burst_rx", {rx_log[u][rb], rx_log[u][rb+1], rx_log[u][rb+2], rx_log[u][rb+3]},
              32'h01020304);
        check("burst_miso", {miso_bytes[0], miso_bytes[1], miso_bytes[2], miso_bytes[3]},
              32'h10203040);
        check("burst_tready", tx_idx[u] - tb0, 4);
        check("burst_fdone", fd_n[u] - fb, 1);
        check("burst_counters", {rxov[u], txun[u]}, 16'h0000);

        // TX underrun
        mosi_bytes[0] = 8'h66; mosi_bytes[1] = 8'h77;
        rb = rx_n[u]; tb0 = tx_idx[u];
        spi_frame(u, 16, 1'b1);
        check("underrun_miso", {miso_bytes[0], miso_bytes[1]}, 16'hFFFF);
        check("underrun_count", txun[u], 8'd2);
        check("underrun_tready", tx_idx[u] - tb0, 0);
        check("underrun_rx", {rx_log[u][rb], rx_log[u][rb+1]}, 16'h6677);

        // RX overflow
        push(u, 8'h01); push(u, 8'h02); push(u, 8'h03);
        mosi_bytes[0] = 8'h11; mosi_bytes[1] = 8'h22; mosi_bytes[2] = 8'h33;
        mtready[u] = 1'b0;
        rb = rx_n[u];
        spi_frame(u, 24, 1'b1);
        check("ovf_hold", {mtvalid[u], mtdata[u]}, {1'b1, 8'h11});
        check("ovf_count", rxov[u], 8'd2);
        check("ovf_no_beat", rx_n[u] - rb, 0);
        check("ovf_txun", txun[u], 8'd2);
        mtready[u] = 1'b1;
        repeat (4) @(negedge clk);
        check("ovf_drain_beats", rx_n[u] - rb, 1);
        check("ovf_drain_rx", rx_log[u][rb], 8'h11);
        check("ovf_drain_valid", mtvalid[u], 1'b0);

        // Partial byte, then a clean frame
        mosi_bytes[0] = 8'h5A;
        rb = rx_n[u]; fb = fd_n[u];
        spi_frame(u, 5, 1'b1);
        check("partial_beats", rx_n[u] - rb, 0);
        check("partial_valid", {mtvalid[u], busy[u]}, 2'b00);
        check("partial_fdone", fd_n[u] - fb, 1);
        check("partial_txun", txun[u], 8'd3);
        push(u, 8'h96);
        rb = rx_n[u];
        spi_frame(u, 8, 1'b1);
        check("after_partial_beats", rx_n[u] - rb, 1);
        check("after_partial_rx", rx_log[u][rb], 8'h5A);
        check("after_partial_miso", miso_bytes[0], 8'h96);

        // Reset mid-frame after 3 bits
        push(u, 8'h55);
        mosi_bytes[0] = 8'hFF;
        spi_frame(u, 3, 1'b0);
        check("midframe_busy", {busy[u], oe[u]}, 2'b11);
        resn = 1'b0;
        repeat (2) @(negedge clk);
        check("midrst_pins", {busy[u], oe[u], miso[u]}, 3'b000);
        check("midrst_axis", {mtvalid[u], stready[u], fdone[u], mtdata[u]}, 11'h000);
        check("midrst_counters", {rxov[u], txun[u]}, 16'h0000);
        csn[u] = 1'b1;
        repeat (2) @(negedge clk);
        resn = 1'b1;
        repeat (5) @(negedge clk);
        push(u, 8'hE7);
        mosi_bytes[0] = 8'hC3;
        rb = rx_n[u]; fb = fd_n[u];
        spi_frame(u, 8, 1'b1);
        check("post_rst_beats", rx_n[u] - rb, 1);
        check("post_rst_rx", rx_log[u][rb], 8'hC3);
        check("post_rst_miso", miso_bytes[0], 8'hE7);
        check("post_rst_fdone", fd_n[u] - fb, 1);
        check("post_rst_counters", {rxov[u], txun[u]}, 16'h0000);

        check("tready_only_with_tvalid", bad_rdy[u], 0);
    endtask

    initial begin
        resn = 1'b0;
        for (int k = 0; k < 2; k++) begin
            sclk[k]    = 1'b0;
            csn[k]     = 1'b1;
            mosi[k]    = 1'b0;
            mtready[k] = 1'b1;
        end
        for (int k = 0; k < 2; k++)
            for (int j = 0; j < 64; j++) tx_list[k][j] = 8'h00;
        for (int j = 0; j < 8; j++) mosi_bytes[j] = 8'h00;
        repeat (4) @(negedge clk);
        run_suite(0);
        run_suite(1);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/spi_axis_slave.md
# spi_axis_slave

SPI responder (mode 0, CPOL=0/CPHA=0) bridging an external SPI master to AXI-Stream inside the housekeeping domain. It oversamples the SPI pins in the `clk` domain and deserialises MOSI into bytes on an AXIS master port. It serialises bytes taken from an AXIS slave port onto MISO. It is the peer of the housekeeping SPI master path and is used as its loop-back/bench counterpart and for external-controller access.

## Interface
Parameters:
- MSB_FIRST, 1, 1: bit 7 is shifted first on both lines; 0: bit 0 first.
- FILL_BYTE, 8'hFF, byte driven on MISO when no TX byte is available.
- SYNC_STAGES, 2, synchroniser depth for spi_clk/spi_csn/spi_mosi (minimum 2).

Ports:
- clk  in  1  single system clock; must be at least 8x the SPI clock frequency.
- resn  in  1  reset, asynchronous, active-low.
- spi_clk  in  1  SPI clock from the master; idles low.
- spi_csn  in  1  chip select, active-low.
- spi_mosi  in  1  master-out data.
- spi_miso  out  1  slave-out data.
- spi_miso_oe  out  1  MISO output enable; 1 while selected.
- m_axis_tdata  out  8  received byte.
- m_axis_tvalid  out  1  received byte valid.
- m_axis_tready  in  1  downstream accept.
- s_axis_tdata  in  8  byte to transmit.
- s_axis_tvalid  in  1  TX byte available.
- s_axis_tready  out  1  one-cycle pulse when a TX byte is loaded.
- busy  out  1  frame in progress (synchronised CSN low).
- frame_done  out  1  one-cycle pulse on synchronised CSN rising edge.
- rx_overflow_count  out  8  saturating count of dropped RX bytes.
- tx_underrun_count  out  8  saturating count of FILL_BYTE substitutions.

## Operation
- Synchronise spi_clk, spi_csn and spi_mosi through SYNC_STAGES flops. Register one more stage for edge detection, which yields sclk_rise, sclk_fall, csn_fall and csn_rise strobes.
- State IDLE → ACTIVE on csn_fall. ACTIVE → IDLE on csn_rise, which has priority over any SCLK edge in the same cycle.
- On csn_fall: load the TX shifter. If s_axis_tvalid is high, load s_axis_tdata and pulse s_axis_tready. Otherwise load FILL_BYTE and increment tx_underrun_count. Drive the first bit on spi_miso in the same cycle the load occurs. Clear bit_cnt to 0.
- ACTIVE, on sclk_rise: shift the synchronised MOSI into the RX shifter and increment bit_cnt, which is 3 bits wide and wraps 7→0.
- When bit_cnt wraps 7→0, the byte is complete:
  - If m_axis_tvalid is 0, or m_axis_tready is high in that cycle, load m_axis_tdata and set m_axis_tvalid.
  - Otherwise drop the new byte, keep the held byte, and increment rx_overflow_count.
- ACTIVE, on sclk_fall: if bit_cnt ≠ 0, drive the next TX bit. If bit_cnt = 0 (a byte boundary) and a byte has completed, load the next TX byte with the same valid/FILL rule as at csn_fall, then drive its first bit.
- m_axis_tvalid clears when m_axis_tready is high and no new byte is loaded in that cycle.
- On csn_rise:
  - Discard any partial RX byte (bit_cnt ≠ 0) without counting it.
  - Reset bit_cnt and pulse frame_done.
  - Leave an already-completed RX byte pending on m_axis.
- spi_miso_oe = busy. When IDLE, spi_miso is driven 0.
- SCLK edges while IDLE are ignored.
- Both counters saturate at 8'hFF and clear only on reset.

## Timing
- Reset values: spi_miso 0, spi_miso_oe 0, m_axis_tdata 8'h00, m_axis_tvalid 0, s_axis_tready 0, busy 0, frame_done 0, both counters 0, state IDLE, bit_cnt 0.
- Pin-to-strobe latency is SYNC_STAGES+1 clk cycles.
- RX latency: m_axis_tvalid rises 1 cycle after the 8th sclk_rise strobe.
- MISO: the next bit appears 1 cycle after the sclk_fall strobe. This is (SYNC_STAGES+2) clk cycles after the pin edge, which must be before the master's next rising edge; this constraint sets the 8x clock ratio.
- The first MISO bit is valid SYNC_STAGES+2 cycles after the CSN pin falls. The master must allow this before its first rising edge.
- s_axis_tready is only ever a single-cycle pulse, and only with s_axis_tvalid high.
- AXIS: tdata is stable while tvalid is high and tready is low. There is no combinational path from tready to tvalid.
- A reset mid-frame returns to IDLE immediately and releases MISO (oe=0). Any partial byte is lost.

## Test plan
- Single frame, MSB_FIRST=1: master sends 8'hA5 while s_axis presents 8'h3C → m_axis delivers 8'hA5 once, master captures 8'h3C, frame_done pulses once, counters stay 0.
- 4-byte burst 01,02,03,04 with TX bytes 10,20,30,40 and tready held 1 → RX order 01..04, MISO carries 10..40, four s_axis_tready pulses, no counter change.
- TX underrun: s_axis_tvalid=0 for a 2-byte frame → MISO carries FF,FF and tx_underrun_count=2.
- RX overflow: tready=0 for 3 received bytes 11,22,33 → m_axis holds 11, rx_overflow_count=2; after tready rises, 11 is accepted and tvalid drops.
- Partial byte: CSN rises after 5 bits → no m_axis beat, bit_cnt=0. The next full frame with 8'h5A is received correctly.
- Reset while ACTIVE after 3 bits → all outputs return to reset values. A subsequent frame with 8'hC3 is received correctly; repeat the whole suite with MSB_FIRST=0.
